// File: rtl/slow_mem_responder.sv
// slow_mem_responder
//   Responder end of the cache-to-slow-memory line interface. It accepts one 128-bit line read
//   or write at a time, models a fixed-latency backing store and answers with a single-cycle
//   mem_ready pulse. A request sampled at rising edge N completes with mem_ready high in the
//   cycle that is sampled at edge N+LATENCY.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   mem_read   in   line read request, held by master until mem_ready
//   mem_write  in   line write request, held by master until mem_ready (wins over mem_read)
//   mem_addr   in   [ADDR_W-1:0] line address; entry index is mem_addr[IDX_W-1:0]
//   mem_wdata  in   [127:0] write line data
//   mem_rdata  out  [127:0] read line data, valid in the mem_ready cycle of a read
//   mem_ready  out  one-cycle completion pulse
//
// Optional build macro MEM_RESP_STAT_EN adds:
//   rd_count   out  [15:0] saturating count of completed reads
//   wr_count   out  [15:0] saturating count of completed writes
module slow_mem_responder #(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_wdata,
    output logic [127:0]      mem_rdata,
    output logic              mem_ready
`ifdef MEM_RESP_STAT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam int unsigned Depth   = 1 << IDX_W;
    localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     wdata_q, wdata_d;
    logic [127:0]     rdata_q, rdata_d;
    logic [127:0]     mem_q [Depth];

    logic             req;
    logic [IDX_W-1:0] req_idx;
    logic             unused_addr;

    assign req         = mem_read | mem_write;
    assign req_idx     = mem_addr[IDX_W-1:0];
    // Upper address bits only alias onto the stored lines.
    assign unused_addr = ^mem_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    wr_d    = mem_write;
                    idx_d   = req_idx;
                    wdata_d = mem_wdata;
                    cnt_d   = CntLoad;
                    if (LATENCY == 1) begin
                        // No busy phase: read data must be loaded on the accepting edge.
                        state_d = StResp;
                        if (!mem_write) begin
                            rdata_d = mem_q[req_idx];
                        end
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 8'd1;
                // Leave when the decremented count reaches zero so mem_rdata is registered
                // on the edge that starts the response cycle.
                if (cnt_q == 8'd1) begin
                    state_d = StResp;
                    if (!wr_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; reset only suppresses a write that is about to commit.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StResp && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_ready = (state_q == StResp);
    assign mem_rdata = rdata_q;

`ifdef MEM_RESP_STAT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_q == StResp) begin
            if (wr_q) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end else if (rd_cnt_q != 16'hFFFF) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: one instance with LATENCY=4 (a_*) and one with LATENCY=1 (b_*).
// Stimulus tasks push the expected response (completion cycle and mem_rdata) into a per-instance
// queue; a monitor per instance pops and compares on every mem_ready pulse.
module tb_slow_mem_responder;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    int           cyc;
    int           total;
    int           bad;

    logic         a_read, a_write, a_ready;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic         b_read, b_write, b_ready;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
`ifdef MEM_RESP_STAT_EN
    logic [15:0]  a_rd_count, a_wr_count, b_rd_count, b_wr_count;
`endif

    exp_t         q_a[$];
    exp_t         q_b[$];
    logic [127:0] last_a, last_b;

    slow_mem_responder #(.ADDR_W(28), .IDX_W(8), .LATENCY(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (a_read),
        .mem_write (a_write),
        .mem_addr  (a_addr),
        .mem_wdata (a_wdata),
        .mem_rdata (a_rdata),
        .mem_ready (a_ready)
`ifdef MEM_RESP_STAT_EN
        ,
        .rd_count  (a_rd_count),
        .wr_count  (a_wr_count)
`endif
    );

    slow_mem_responder #(.ADDR_W(28), .IDX_W(8), .LATENCY(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (b_read),
        .mem_write (b_write),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
        .mem_rdata (b_rdata),
        .mem_ready (b_ready)
`ifdef MEM_RESP_STAT_EN
        ,
        .rd_count  (b_rd_count),
        .wr_count  (b_wr_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: every mem_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (a_ready) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_ready: got pulse expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_ready_cycle", 128'(cyc), 128'(e.cyc));
                chk("a_rdata", a_rdata, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b_ready) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_ready: got pulse expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_ready_cycle", 128'(cyc), 128'(e.cyc));
                chk("b_rdata", b_rdata, e.data);
            end
        end
    end

    // Called at a falling edge. Holds the request through the ready cycle and drops it at the
    // following falling edge, before the responder's idle cycle samples it.
    task automatic txn(input int d, input bit wr, input logic [27:0] addr,
                       input logic [127:0] dat);
        exp_t e;
        int   n;
        bit   rdy;
        e.cyc  = cyc + ((d == 0) ? 4 : 1);
        e.data = wr ? ((d == 0) ? last_a : last_b) : dat;
        if (d == 0) begin
            if (!wr) last_a = dat;
            q_a.push_back(e);
            a_read  = !wr;
            a_write = wr;
            a_addr  = addr;
            a_wdata = wr ? dat : '0;
        end else begin
            if (!wr) last_b = dat;
            q_b.push_back(e);
            b_read  = !wr;
            b_write = wr;
            b_addr  = addr;
            b_wdata = wr ? dat : '0;
        end
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            rdy = (d == 0) ? a_ready : b_ready;
            if (rdy) break;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL txn_timeout: got no mem_ready expected one (dut %0d)", d);
                break;
            end
        end
        @(negedge clk);
        if (d == 0) begin
            a_read  = 1'b0;
            a_write = 1'b0;
        end else begin
            b_read  = 1'b0;
            b_write = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        last_a = '0;
        last_b = '0;
    endtask

    localparam logic [127:0] DatDb = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] DatA  = 128'hAAAA_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] DatB  = 128'hBBBB_8888_9999_0000_1212_3434_5656_7878;
    localparam logic [127:0] DatC  = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
    localparam logic [127:0] DatD  = 128'h0D0D_0D0D_1357_9BDF_2468_ACE0_0D0D_0D0D;
    localparam logic [127:0] DatE  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DatF  = 128'hF00D_CAFE_0000_1111_2222_3333_4444_5555;

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        last_a  = '0;
        last_b  = '0;
        rst     = 1'b1;
        a_read  = 1'b0;
        a_write = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        b_read  = 1'b0;
        b_write = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        idle(3);
        rst = 1'b0;
        chk("a_reset_ready", 128'(a_ready), 128'd0);
        chk("a_reset_rdata", a_rdata, 128'd0);
        chk("b_reset_ready", 128'(b_ready), 128'd0);
        chk("b_reset_rdata", b_rdata, 128'd0);
        idle(2);

        // Write then read the same line; the read hold/drop is followed by a quiet window in
        // which the monitor would flag any second pulse.
        txn(0, 1'b1, 28'h0000010, DatDb);
        txn(0, 1'b0, 28'h0000010, DatDb);
        idle(8);

        // Aliasing: 0x003 and 0x103 share index 3.
        txn(0, 1'b1, 28'h0000003, DatA);
        txn(0, 1'b1, 28'h0000103, DatB);
        txn(0, 1'b0, 28'h0000003, DatB);

        // Seed line 5, then abort a write to it two cycles in.
        txn(0, 1'b1, 28'h0000005, DatD);
        a_write = 1'b1;
        a_addr  = 28'h0000005;
        a_wdata = DatC;
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        a_write = 1'b0;
        last_a  = '0;
        last_b  = '0;
        chk("a_abort_ready", 128'(a_ready), 128'd0);
        chk("a_abort_rdata", a_rdata, 128'd0);
        idle(6);
        txn(0, 1'b0, 28'h0000005, DatD);

        // LATENCY=1: fill two lines, then back-to-back reads (pulses two cycles apart).
        txn(1, 1'b1, 28'h0000001, DatE);
        txn(1, 1'b1, 28'h0000002, DatF);
        txn(1, 1'b0, 28'h0000001, DatE);
        txn(1, 1'b0, 28'h0000002, DatF);
        idle(4);

`ifdef MEM_RESP_STAT_EN
        do_reset();
        txn(0, 1'b1, 28'h0000020, DatA);
        txn(0, 1'b1, 28'h0000021, DatB);
        txn(0, 1'b0, 28'h0000020, DatA);
        txn(0, 1'b0, 28'h0000021, DatB);
        txn(0, 1'b0, 28'h0000010, DatDb);
        idle(2);
        chk("a_rd_count", 128'(a_rd_count), 128'd3);
        chk("a_wr_count", 128'(a_wr_count), 128'd2);
        do_reset();
        chk("a_rd_count_rst", 128'(a_rd_count), 128'd0);
        chk("a_wr_count_rst", 128'(a_wr_count), 128'd0);
`endif

        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL missing_responses: got %0d/%0d outstanding expected 0/0",
                     q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
